// File: rtl/multi_sensor_monitor.sv
// multi_sensor_monitor: per-channel XADC averaging with sticky alarms and a periodic AXI-Stream status report
module multi_sensor_monitor #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_DIV = 100_000_000,
  parameter int AVG_LOG2   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       adc_data,
  input  logic [3:0]        adc_chan,
  input  logic              adc_ready,
  input  logic [11:0]       alarm_thresh,
  input  logic              alarm_clr,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [NUM_CH-1:0] alarm,
  output logic [7:0]        overrun_cnt
);
  localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [CW-1:0]   div_q, div_d;
  logic            tick_q, tick_d;
  logic [AW-1:0]   acc_q [NUM_CH];
  logic [AW-1:0]   acc_d [NUM_CH];
  logic [NW-1:0]   cnt_q [NUM_CH];
  logic [NW-1:0]   cnt_d [NUM_CH];
  logic [11:0]     avg_q [NUM_CH];
  logic [11:0]     avg_d [NUM_CH];
  logic [AW-1:0]   sum [NUM_CH];
  logic [11:0]     new_avg [NUM_CH];
  logic [NUM_CH-1:0] fresh_q, fresh_d, alarm_q, alarm_d, hit, latch;
  logic            smp_ok;
  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, load_idx;
  logic            load;
  logic [31:0]     tdata_q, tdata_d, beat;
  logic            tlast_q, tlast_d;
  logic [7:0]      ovr_q, ovr_d;
  logic            unused_lsbs;

  assign unused_lsbs = &{1'b0, adc_data[3:0]};
  assign smp_ok = adc_ready && ({1'b0, adc_chan} < 5'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign hit[g]     = smp_ok && adc_chan == 4'(g);
    assign sum[g]     = acc_q[g] + AW'(adc_data[15:4]);
    assign latch[g]   = hit[g] && (cnt_q[g] + NW'(1)) == NW'(1 << AVG_LOG2);
    assign new_avg[g] = sum[g][AW-1:AVG_LOG2];
  end

  // report period divider; tick is registered so it lands the cycle after the wrap value
  always_comb begin
    tick_d = div_q == CW'(SAMPLE_DIV - 1);
    div_d  = tick_d ? '0 : div_q + CW'(1);
  end

  // tick divider registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  // per-channel accumulate/latch; a latch beats a same-cycle beat load on fresh, and alarm set beats clear
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c]   = hit[c] ? (latch[c] ? '0 : sum[c]) : acc_q[c];
      cnt_d[c]   = hit[c] ? (latch[c] ? '0 : cnt_q[c] + NW'(1)) : cnt_q[c];
      avg_d[c]   = latch[c] ? new_avg[c] : avg_q[c];
      fresh_d[c] = latch[c] || (fresh_q[c] && !(load && load_idx == IW'(c)));
      alarm_d[c] = (latch[c] && new_avg[c] > alarm_thresh) || (alarm_q[c] && !alarm_clr);
    end
  end

  // channel state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      avg_q   <= '{default: '0};
      fresh_q <= '0;
      alarm_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      fresh_q <= fresh_d;
      alarm_q <= alarm_d;
    end
  end

  assign beat = {4'(load_idx), 4'h0, fresh_q[load_idx], alarm_q[load_idx], 10'h0, avg_q[load_idx]};

  // report FSM: load beat 0 on tick, advance on handshake, drop ticks that arrive mid-frame
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = idx_q;
    case (state_q)
      IDLE: if (tick_q) begin
        state_d  = SEND;
        load     = 1'b1;
        load_idx = '0;
      end
      SEND: if (m_axis_tready) begin
        if (idx_q == LAST) state_d = IDLE;
        else begin
          load     = 1'b1;
          load_idx = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    idx_d   = load ? load_idx : idx_q;
    tdata_d = load ? beat : tdata_q;
    tlast_d = load ? load_idx == LAST : tlast_q;
    ovr_d   = (tick_q && state_q == SEND && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
  end

  // report registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_axis_tvalid = state_q == SEND;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign alarm         = alarm_q;
  assign overrun_cnt   = ovr_q;
endmodule
